// File: rtl/wb_regfile.sv
// Writeback stage: decodes the WB instruction, commits results to a 32x32 register file,
// serves two bypassed read ports and counts retired instructions. `WB_LOAD_EXT_EN adds lb/lbu/lh/lhu.
module wb_regfile #(
    parameter int          NREG         = 32,
    parameter logic [31:0] RESET_PC_TAG = 32'h0000_3000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] IR_WB,
    input  logic [31:0] PC4_WB,
    input  logic [31:0] AO_WB,
    input  logic [31:0] DR_WB,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] instret,
    output logic [31:0] trace_pc
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
`ifdef WB_LOAD_EXT_EN
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
`endif

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        writes;
    logic [4:0]  dest;
    logic [31:0] selData;
    logic [31:0] regs_q [NREG];
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        unused_irFields;

    assign op              = IR_WB[31:26];
    assign rt              = IR_WB[20:16];
    assign rd              = IR_WB[15:11];
    assign funct           = IR_WB[5:0];
    assign unused_irFields = ^{IR_WB[25:21], IR_WB[10:6]};

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    // Little-endian lane pick; halfword ignores AO_WB[0] so misaligned accesses still resolve.
    always_comb begin
        ldByte = DR_WB[7:0];
        case (AO_WB[1:0])
            2'd0: ldByte = DR_WB[7:0];
            2'd1: ldByte = DR_WB[15:8];
            2'd2: ldByte = DR_WB[23:16];
            2'd3: ldByte = DR_WB[31:24];
            default: ldByte = DR_WB[7:0];
        endcase
        ldHalf = AO_WB[1] ? DR_WB[31:16] : DR_WB[15:0];
    end
`endif

    always_comb begin
        writes  = 1'b0;
        dest    = 5'd0;
        selData = 32'h0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    writes  = 1'b1;
                    dest    = rd;
                    selData = AO_WB;
                end
            end
            OP_ORI, OP_LUI: begin
                writes  = 1'b1;
                dest    = rt;
                selData = AO_WB;
            end
            OP_LW: begin
                writes  = 1'b1;
                dest    = rt;
                selData = DR_WB;
            end
            OP_JAL: begin
                writes  = 1'b1;
                dest    = 5'd31;
                selData = PC4_WB + 32'd4;
            end
`ifdef WB_LOAD_EXT_EN
            OP_LB: begin
                writes  = 1'b1;
                dest    = rt;
                selData = {{24{ldByte[7]}}, ldByte};
            end
            OP_LBU: begin
                writes  = 1'b1;
                dest    = rt;
                selData = {24'h0, ldByte};
            end
            OP_LH: begin
                writes  = 1'b1;
                dest    = rt;
                selData = {{16{ldHalf[15]}}, ldHalf};
            end
            OP_LHU: begin
                writes  = 1'b1;
                dest    = rt;
                selData = {16'h0, ldHalf};
            end
`endif
            default: begin
                writes  = 1'b0;
                dest    = 5'd0;
                selData = 32'h0;
            end
        endcase
    end

    // Writes targeting $0 are squashed here so the forwarding unit never sees them.
    assign wb_we   = writes && (dest != 5'd0);
    assign wb_addr = wb_we ? dest : 5'd0;
    assign wb_data = wb_we ? selData : 32'h0;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (wb_we) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign instret_d = (IR_WB != 32'h0) ? instret_q + 32'd1 : instret_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            instret_q <= 32'h0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign RD1 = (A1 == 5'd0) ? 32'h0 : (wb_we && A1 == wb_addr) ? wb_data : regs_q[A1];
    assign RD2 = (A2 == 5'd0) ? 32'h0 : (wb_we && A2 == wb_addr) ? wb_data : regs_q[A2];

    assign instret  = instret_q;
    assign trace_pc = PC4_WB - 32'd4 - RESET_PC_TAG;

endmodule
